// File: rtl/layer_header_sequencer.sv
// Walks the per-layer header words in register memory, assembles each enabled layer's header and
// presents it over a valid/ready handshake, while arbitrating host writes against the live layer.
module layer_header_sequencer #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned WORDS_PER_LAYER = 4,
  parameter int unsigned NUM_LAYERS      = 8,
  localparam int unsigned DEPTH = WORDS_PER_LAYER * NUM_LAYERS,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  frame_start,
  output logic                                  busy,
  output logic                                  frame_done,
  input  logic                                  host_wr_req,
  input  logic [AW-1:0]                         host_wr_addr,
  input  logic [DATA_WIDTH-1:0]                 host_wr_data,
  output logic                                  host_wr_ack,
  output logic                                  mem_write_en,
  output logic [AW-1:0]                         mem_rw_addr,
  output logic [DATA_WIDTH-1:0]                 mem_write_data,
  output logic [AW-1:0]                         mem_read_addr,
  input  logic [DATA_WIDTH-1:0]                 mem_read_data,
  output logic                                  hdr_valid,
  input  logic                                  hdr_ready,
  output logic [DATA_WIDTH*WORDS_PER_LAYER-1:0] hdr_data,
  output logic [LW-1:0]                         hdr_layer
);

  localparam int unsigned WW = (WORDS_PER_LAYER > 1) ? $clog2(WORDS_PER_LAYER) : 1;
  localparam int unsigned HW = DATA_WIDTH * WORDS_PER_LAYER;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StFetch   = 2'd1;
  localparam logic [1:0] StPresent = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [WW-1:0] word_q, word_d;
  logic [HW-1:0] hdr_q, hdr_d;
  logic          last_word, last_layer, layer_en, blocked;
  logic [AW-1:0] wr_layer;

  assign last_word  = (word_q == WW'(WORDS_PER_LAYER - 1));
  assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));
  // With a single word per layer the enable bit is still on the read bus, not yet in a slot.
  assign layer_en   = (WORDS_PER_LAYER == 1) ? mem_read_data[0] : hdr_q[0];

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    word_d  = word_q;
    hdr_d   = hdr_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          layer_d = '0;
          word_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        hdr_d[word_q*DATA_WIDTH +: DATA_WIDTH] = mem_read_data;
        if (!last_word) begin
          word_d = word_q + 1'b1;
        end else if (layer_en) begin
          state_d = StPresent;
        end else if (!last_layer) begin
          layer_d = layer_q + 1'b1;
          word_d  = '0;
        end else begin
          state_d = StDone;
        end
      end
      StPresent: begin
        if (hdr_ready) begin
          if (!last_layer) begin
            layer_d = layer_q + 1'b1;
            word_d  = '0;
            state_d = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      layer_q <= '0;
      word_q  <= '0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      word_q  <= word_d;
      hdr_q   <= hdr_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);
  assign hdr_valid  = (state_q == StPresent);
  assign hdr_data   = hdr_q;
  assign hdr_layer  = layer_q;

  assign mem_read_addr = (state_q == StFetch) ?
                         AW'(layer_q) * AW'(WORDS_PER_LAYER) + AW'(word_q) : '0;

  // Host writes may not touch the layer currently being fetched or presented.
  assign wr_layer       = host_wr_addr / AW'(WORDS_PER_LAYER);
  assign blocked        = ((state_q == StFetch) || (state_q == StPresent)) &&
                          (wr_layer == AW'(layer_q));
  assign host_wr_ack    = host_wr_req && !blocked;
  assign mem_write_en   = host_wr_ack;
  assign mem_rw_addr    = host_wr_addr;
  assign mem_write_data = host_wr_data;

endmodule

// File: tb/tb_layer_header_sequencer.sv
// Scoreboard bench: stimulus pushes expected headers/done times from a memory-level model,
// a negedge monitor pops and compares whenever the DUT presents a header or frame_done.
module tb_layer_header_sequencer;

  localparam int DW = 16;
  localparam int WPL = 4;
  localparam int NL = 8;

  typedef struct packed {
    logic [2:0]  layer;
    logic [63:0] data;
  } hdr_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        frame_start = 0;
  logic        busy, frame_done;
  logic        host_wr_req = 0;
  logic [4:0]  host_wr_addr = '0;
  logic [15:0] host_wr_data = '0;
  logic        host_wr_ack, mem_write_en;
  logic [4:0]  mem_rw_addr, mem_read_addr;
  logic [15:0] mem_write_data, mem_read_data;
  logic        hdr_valid;
  logic        hdr_ready = 1;
  logic [63:0] hdr_data;
  logic [2:0]  hdr_layer;

  logic [15:0] mem [32];
  logic [15:0] ref_mem [32];
  hdr_t        exp_hdr [$];
  int          exp_done [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  hdr_t        mon_e;
  int          mon_d;

  layer_header_sequencer #(
    .DATA_WIDTH     (DW),
    .WORDS_PER_LAYER(WPL),
    .NUM_LAYERS     (NL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .busy          (busy),
    .frame_done    (frame_done),
    .host_wr_req   (host_wr_req),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_wr_ack   (host_wr_ack),
    .mem_write_en  (mem_write_en),
    .mem_rw_addr   (mem_rw_addr),
    .mem_write_data(mem_write_data),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data),
    .hdr_valid     (hdr_valid),
    .hdr_ready     (hdr_ready),
    .hdr_data      (hdr_data),
    .hdr_layer     (hdr_layer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register memory: synchronous write, asynchronous read.
  always @(posedge clk) if (mem_write_en) mem[mem_rw_addr] <= mem_write_data;
  assign mem_read_data = mem[mem_read_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: compares every handshake and frame_done against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid && hdr_ready) begin
        if (exp_hdr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_header: got layer %0d, none expected", hdr_layer);
        end else begin
          mon_e = exp_hdr.pop_front();
          check("hdr_layer", 64'(hdr_layer), 64'(mon_e.layer));
          check("hdr_data", hdr_data, mon_e.data);
        end
      end
      if (frame_done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: got pulse at cycle %0d, none expected", cyc);
        end else begin
          mon_d = exp_done.pop_front();
          if (mon_d >= 0) check("frame_done_cycle", 64'(cyc), 64'(mon_d));
        end
      end
    end
  end

  // Cycle (relative to frame_start) at which layer l starts fetching, with ready held high.
  function automatic int layer_start(input int l);
    int t = 1;
    for (int j = 0; j < l; j++) t += ref_mem[j*WPL][0] ? WPL + 1 : WPL;
    return t;
  endfunction

  task automatic expect_pass(input int c0, input int extra, input bit timed);
    hdr_t h;
    for (int l = 0; l < NL; l++) begin
      if (ref_mem[l*WPL][0]) begin
        h.layer = 3'(l);
        h.data  = {ref_mem[l*WPL+3], ref_mem[l*WPL+2], ref_mem[l*WPL+1], ref_mem[l*WPL]};
        exp_hdr.push_back(h);
      end
    end
    exp_done.push_back(timed ? c0 + layer_start(NL) + extra : -1);
  endtask

  task automatic start_pass(input bit timed, input int extra, output int c0);
    @(posedge clk); #1;
    c0 = cyc;
    expect_pass(c0, extra, timed);
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    host_wr_req  = 1;
    host_wr_addr = a;
    host_wr_data = d;
    @(negedge clk);
    check("idle_wr_ack", 64'(host_wr_ack), 64'(1));
    check("idle_wr_addr", 64'(mem_rw_addr), 64'(a));
    @(posedge clk); #1;
    host_wr_req = 0;
    ref_mem[a] = d;
  endtask

  // mode 0: all layers enabled; 1: only layers 2 and 5; otherwise random enables.
  task automatic load_mem(input int mode);
    for (int a = 0; a < 32; a++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (a % WPL == 0) begin
        case (mode)
          0:       d[0] = 1'b1;
          1:       d[0] = (a / WPL == 2) || (a / WPL == 5);
          default: d[0] = ($urandom_range(0, 2) != 0);
        endcase
      end
      host_write(5'(a), d);
    end
  endtask

  task automatic host_try(input logic [4:0] addr, input logic [15:0] data, input int c0);
    bit granted = 0;
    int l = int'(addr) / WPL;
    for (int i = 0; i < 30 && !granted; i++) begin
      int  k;
      bit  want;
      host_wr_req  = 1;
      host_wr_addr = addr;
      host_wr_data = data;
      k    = cyc - c0;
      want = !(k >= layer_start(l) && k < layer_start(l + 1));
      @(negedge clk);
      check("host_wr_ack", 64'(host_wr_ack), 64'(want));
      check("mem_write_en", 64'(mem_write_en), 64'(want));
      if (want) begin
        check("mem_rw_addr", 64'(mem_rw_addr), 64'(addr));
        check("mem_write_data", 64'(mem_write_data), 64'(data));
        granted = 1;
      end
      @(posedge clk); #1;
    end
    host_wr_req = 0;
    ref_mem[addr] = data;
  endtask

  task automatic wait_done(input bit rand_ready);
    for (int i = 0; i < 500 && (exp_hdr.size() != 0 || exp_done.size() != 0); i++) begin
      @(posedge clk); #1;
      if (rand_ready) hdr_ready = 1'($urandom_range(0, 1));
    end
    hdr_ready = 1;
    check("pending_headers", 64'(exp_hdr.size()), 64'(0));
    check("pending_frame_done", 64'(exp_done.size()), 64'(0));
    @(posedge clk); #1;
    check("idle_after_pass", 64'(busy), 64'(0));
  endtask

  task automatic mem_compare();
    for (int a = 0; a < 32; a++) check("mem_word", 64'(mem[a]), 64'(ref_mem[a]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int  c0;
    bit  seen;
    logic [15:0] d20, d5;

    // Reset state, with a host request outstanding in IDLE.
    host_wr_req  = 1;
    host_wr_addr = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_hdr_valid", 64'(hdr_valid), 64'(0));
    check("rst_hdr_data", hdr_data, 64'(0));
    check("rst_hdr_layer", 64'(hdr_layer), 64'(0));
    check("rst_mem_read_addr", 64'(mem_read_addr), 64'(0));
    check("rst_wr_ack", 64'(host_wr_ack), 64'(1));
    @(posedge clk); #1;
    rst = 0;
    host_wr_req = 0;

    // All layers enabled, with an extra frame_start mid-pass that must be ignored.
    load_mem(0);
    start_pass(1, 0, c0);
    repeat (9) begin @(posedge clk); #1; end
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
    wait_done(0);

    // Only layers 2 and 5 enabled.
    load_mem(1);
    start_pass(1, 0, c0);
    wait_done(0);

    // Consumer stalls for 10 cycles on layer 0.
    load_mem(0);
    hdr_ready = 0;
    start_pass(1, 10, c0);
    repeat (4) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(hdr_valid), 64'(1));
      check("stall_layer", 64'(hdr_layer), 64'(0));
      check("stall_data", hdr_data, exp_hdr.size() != 0 ? exp_hdr[0].data : 64'(0));
      @(posedge clk); #1;
    end
    hdr_ready = 1;
    wait_done(0);

    // Host writes during a pass: layer 5 write goes straight through, layer 1 write waits.
    d20 = 16'($urandom) | 16'd1;
    d5  = 16'($urandom);
    ref_mem[20] = d20;
    start_pass(1, 0, c0);
    repeat (5) begin @(posedge clk); #1; end
    host_try(5'd20, d20, c0);
    host_try(5'd5, d5, c0);
    wait_done(0);
    mem_compare();

    // Reset while a header is presented aborts the pass without frame_done.
    hdr_ready = 0;
    start_pass(0, 0, c0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = hdr_valid;
    end
    check("valid_before_reset", 64'(seen), 64'(1));
    @(posedge clk); #1;
    rst = 1;
    exp_hdr.delete();
    exp_done.delete();
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", 64'(hdr_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_frame_done", 64'(frame_done), 64'(0));
    check("abort_hdr_data", hdr_data, 64'(0));
    @(posedge clk); #1;
    rst = 0;
    hdr_ready = 1;
    repeat (5) begin @(posedge clk); #1; end
    check("abort_idle", 64'(busy), 64'(0));
    start_pass(1, 0, c0);
    wait_done(0);

    // Random contents, random enables, random consumer backpressure.
    for (int p = 0; p < 4; p++) begin
      load_mem(2);
      start_pass(0, 0, c0);
      wait_done(1);
    end
    mem_compare();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
